// File: rtl/debounce_defs.sv
// debounce_defs: shared FSM state encoding for debounce_sync
package debounce_defs;
  typedef enum logic [1:0] {
    IDLE_LOW  = 2'd0,
    WAIT_HIGH = 2'd1,
    IDLE_HIGH = 2'd2,
    WAIT_LOW  = 2'd3
  } state_t;
endpackage

// File: rtl/sync_chain.sv
// sync_chain: multi-flop synchronizer, asynchronously cleared to 0
module sync_chain #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);
  logic [STAGES-1:0] r;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r <= '0;
    else r <= {r[STAGES-2:0], d};
  assign q = r[STAGES-1];
endmodule

// File: rtl/debounce_sync.sv
// debounce_sync: synchronize and debounce a raw input into a clean level plus edge pulses
module debounce_sync
  import debounce_defs::*;
#(
  parameter int SYNC_STAGES     = 2,
  parameter int CNT_W           = 16,
  parameter int DEBOUNCE_CYCLES = 1000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic q,
  output logic qbar,
  output logic rise,
  output logic fall,
  output logic busy
);
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(DEBOUNCE_CYCLES);
  localparam bit ONE_SHOT = DEBOUNCE_CYCLES == 1;
  logic s;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_inc;
  state_t state;
  sync_chain #(.STAGES(SYNC_STAGES)) u_sync (.clk(clk), .rst_n(rst_n), .d(din), .q(s));
  assign cnt_inc = cnt + 1'b1;
  assign qbar = ~q;
  // busy is set alongside every state update so it mirrors the WAIT states
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE_LOW;
      cnt   <= '0;
      q     <= 1'b0;
      rise  <= 1'b0;
      fall  <= 1'b0;
      busy  <= 1'b0;
    end else begin
      rise <= 1'b0;
      fall <= 1'b0;
      unique case (state)
        IDLE_LOW:
          if (s) begin
            state <= ONE_SHOT ? IDLE_HIGH : WAIT_HIGH;
            cnt   <= ONE_SHOT ? '0 : CNT_W'(1);
            q     <= ONE_SHOT;
            rise  <= ONE_SHOT;
            busy  <= !ONE_SHOT;
          end
        WAIT_HIGH:
          if (!s) begin
            state <= IDLE_LOW;
            cnt   <= '0;
            busy  <= 1'b0;
          end else if (cnt_inc == LIMIT) begin
            state <= IDLE_HIGH;
            cnt   <= '0;
            q     <= 1'b1;
            rise  <= 1'b1;
            busy  <= 1'b0;
          end else cnt <= cnt_inc;
        IDLE_HIGH:
          if (!s) begin
            state <= ONE_SHOT ? IDLE_LOW : WAIT_LOW;
            cnt   <= ONE_SHOT ? '0 : CNT_W'(1);
            q     <= !ONE_SHOT;
            fall  <= ONE_SHOT;
            busy  <= !ONE_SHOT;
          end
        WAIT_LOW:
          if (s) begin
            state <= IDLE_HIGH;
            cnt   <= '0;
            busy  <= 1'b0;
          end else if (cnt_inc == LIMIT) begin
            state <= IDLE_LOW;
            cnt   <= '0;
            q     <= 1'b0;
            fall  <= 1'b1;
            busy  <= 1'b0;
          end else cnt <= cnt_inc;
      endcase
    end
endmodule

// File: tb/tb_debounce_sync.sv
// tb_debounce_sync: directed checks of debounce_sync with 2 sync stages and a 4-sample window
module tb_debounce_sync;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic din = 1'b1;
  logic q, qbar, rise, fall, busy;
  int checks = 0;
  int errors = 0;
  int rises;
  debounce_sync #(.SYNC_STAGES(2), .CNT_W(4), .DEBOUNCE_CYCLES(4)) dut (
    .clk(clk), .rst_n(rst_n), .din(din), .q(q), .qbar(qbar),
    .rise(rise), .fall(fall), .busy(busy)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic got, input logic exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %b expected %b", tag, got, exp);
    end
  endtask
  task automatic chk_all(input string tag, input logic eq, input logic er, input logic ef, input logic eb);
    chk({tag, ".q"}, q, eq);
    chk({tag, ".qbar"}, qbar, ~eq);
    chk({tag, ".rise"}, rise, er);
    chk({tag, ".fall"}, fall, ef);
    chk({tag, ".busy"}, busy, eb);
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  initial begin
    #2 rst_n = 1'b0;
    #1 chk_all("reset", 1'b0, 1'b0, 1'b0, 1'b0);
    din = 1'b0;
    #1 rst_n = 1'b1;
    repeat (3) tick();
    chk_all("idle", 1'b0, 1'b0, 1'b0, 1'b0);
    din = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      tick();
      chk_all($sformatf("rise_e%0d", i), i >= 6, i == 6, 1'b0, i >= 3 && i <= 5);
    end
    din = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      tick();
      chk_all($sformatf("fall_e%0d", i), i < 6, 1'b0, i == 6, i >= 3 && i <= 5);
    end
    din = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      tick();
      if (i == 3) din = 1'b0;
      chk_all($sformatf("glitch_e%0d", i), 1'b0, 1'b0, 1'b0, i >= 3 && i <= 5);
    end
    rises = 0;
    for (int i = 0; i < 20; i++) begin
      din = (i % 2) == 0;
      tick();
      rises += int'(rise);
      chk($sformatf("bounce_q%0d", i), q, 1'b0);
    end
    din = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      tick();
      rises += int'(rise);
      chk($sformatf("bounce_q_e%0d", i), q, i >= 6);
      chk($sformatf("bounce_excl_e%0d", i), rise & fall, 1'b0);
    end
    chk("bounce_one_rise", rises == 1, 1'b1);
    din = 1'b0;
    rst_n = 1'b0;
    #1 rst_n = 1'b1;
    repeat (3) tick();
    din = 1'b1;
    for (int i = 1; i <= 4; i++) tick();
    chk("midq_busy_before", busy, 1'b1);
    #1 rst_n = 1'b0;
    #1 chk_all("midq_reset", 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 5; i <= 10; i++) begin
      tick();
      chk_all($sformatf("midq_hold_e%0d", i), 1'b0, 1'b0, 1'b0, 1'b0);
    end
    rst_n = 1'b1;
    for (int i = 11; i <= 17; i++) begin
      tick();
      chk_all($sformatf("midq_e%0d", i), i >= 16, i == 16, 1'b0, i >= 13 && i <= 15);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
